// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Moore control FSM for the multicycle MIPS datapath. It sequences PC, memory,
// IR, register file, the ALU input muxes and the ALU control block for R-type,
// lw, sw, beq and j. A memory read occupies MEM_LATENCY cycles in FETCH and
// MEM_READ. Unsupported opcodes are flagged in DECODE, and the instruction is
// dropped.
//
// Parameters
//   MEM_LATENCY  cycles per memory read, legal range 1..15
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   opcode       IR[31:26], valid from DECODE onward
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load qualified by ALU zero (the AND is in the datapath)
//   IorD         memory address select: 0 PC, 1 ALUOut
//   MemRead      memory read enable
//   MemWrite     memory write enable
//   IRWrite      instruction register load
//   RegDst       write register select: 0 rt, 1 rd
//   MemtoReg     write data select: 0 ALUOut, 1 MDR
//   RegWrite     register file write
//   ALUSrcA      ALU A select: 0 PC, 1 rs
//   ALUSrcB      ALU B select: 00 rt, 01 4, 10 simm, 11 simm<<2
//   ULAOp        to AluControl: 00 add, 01 subtract, 10 by funct
//   PCSource     PC input select: 00 ALU result, 01 ALUOut, 10 jump target
//   instr_done   one-cycle pulse in the final state of each instruction
//   illegal_op   one-cycle pulse when DECODE sees an unsupported opcode
//   state_dbg    current state encoding
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ULAOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10
    } state_t;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;

    // Counter value on the final cycle of a memory-read state.
    localparam logic [3:0] WAIT_LAST = 4'(MEM_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       wait_last;

    assign wait_last = (wait_cnt == WAIT_LAST);
    assign state_dbg = state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_RST;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            // Restart the count whenever a state is entered; count up while
            // dwelling in one of the memory-read states.
            if (state_next != state)
                wait_cnt <= '0;
            else if (state == ST_FETCH || state == ST_MEM_READ)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // NOTE: every output and state_next gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_next  = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ULAOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;

        unique case (state)
            ST_RST: state_next = ST_FETCH;

            ST_FETCH: begin
                MemRead = 1'b1;
                // IR load and PC+4 happen only once the read data is valid.
                if (wait_last) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    ALUSrcB    = 2'b01;
                    state_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Precompute the branch target into ALUOut.
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_next = ST_MEM_ADDR;
                    OP_R:         state_next = ST_R_EXEC;
                    OP_BEQ:       state_next = ST_BRANCH;
                    OP_J:         state_next = ST_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = ST_FETCH;
                    end
                endcase
            end

            ST_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            end

            ST_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (wait_last)
                    state_next = ST_MEM_WB;
            end

            ST_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_next = ST_FETCH;
            end

            ST_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = 1'b1;
                state_next = ST_FETCH;
            end

            ST_R_EXEC: begin
                ALUSrcA    = 1'b1;
                ULAOp      = 2'b10;
                state_next = ST_R_WB;
            end

            ST_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_next = ST_FETCH;
            end

            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ULAOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                state_next  = ST_FETCH;
            end

            ST_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                state_next = ST_FETCH;
            end

            // Encodings 11..15: all outputs stay 0, recover to FETCH.
            default: state_next = ST_FETCH;
        endcase
    end

endmodule
